// File: rtl/spi_int_ctrl_pkg.sv
// spi_int_pkg: shared register addresses, source indices and mode encodings for spi_int_ctrl
package spi_int_pkg;
    localparam logic [1:0] ADDR_IER  = 2'd0;
    localparam logic [1:0] ADDR_ISR  = 2'd1;
    localparam logic [1:0] ADDR_RAW  = 2'd2;
    localparam logic [1:0] ADDR_MODE = 2'd3;
    localparam int SRC_TX_EMPTY = 0;
    localparam int SRC_TX_FULL  = 1;
    localparam int SRC_RX_EMPTY = 2;
    localparam int SRC_RX_FULL  = 3;
    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;
endpackage

// File: rtl/spi_int_ctrl_if.sv
// spi_int_ctrl_if: register access bus between the APB decoder (master) and spi_int_ctrl (slave)
//   i_wr_en/i_rd_en one-cycle strobes, i_addr register index, i_wdata write data,
//   o_rdata read data registered the cycle after i_rd_en
interface spi_int_ctrl_if #(parameter int DATA_W = 8);
    logic              i_wr_en;
    logic              i_rd_en;
    logic [1:0]        i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] o_rdata;
    modport master (output i_wr_en, i_rd_en, i_addr, i_wdata, input o_rdata);
    modport slave  (input i_wr_en, i_rd_en, i_addr, i_wdata, output o_rdata);
endinterface

// File: rtl/spi_int_ctrl_src.sv
// spi_int_src: one interrupt source -- flag history, rising-edge detect and pending bit
//   pclk/presetn clock and async active-low reset, flag live status, mode 0 level / 1 edge,
//   w1c write-1-to-clear strobe, pend pending bit
module spi_int_src
    import spi_int_pkg::*;
(
    input  logic pclk,
    input  logic presetn,
    input  logic flag,
    input  logic mode,
    input  logic w1c,
    output logic pend
);
    logic flag_q;
    // In edge mode a new rise beats a simultaneous clear so an event is never lost.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            flag_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            flag_q <= flag;
            pend   <= (mode == MODE_EDGE) ? ((flag & ~flag_q) | (pend & ~w1c)) : flag;
        end
    end
endmodule

// File: rtl/spi_int_ctrl.sv
// spi_int_ctrl: SPI FIFO-flag interrupt controller with IER/ISR(W1C)/RAW/MODE registers and registered IRQ
//   pclk/presetn clock and async active-low reset, i_flag live FIFO flags,
//   bus register access (slave side), o_int registered interrupt request
module spi_int_ctrl
    import spi_int_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NUM_SRC-1:0] i_flag,
    spi_int_ctrl_if.slave      bus,
    output logic               o_int
);
    logic [NUM_SRC-1:0] ier;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] wsrc;
    logic [NUM_SRC-1:0] rd_sel;
    logic               wr_ier;
    logic               wr_mode;
    assign wsrc    = bus.i_wdata[NUM_SRC-1:0];
    assign wr_ier  = bus.i_wr_en && (bus.i_addr == ADDR_IER);
    assign wr_mode = bus.i_wr_en && (bus.i_addr == ADDR_MODE);
    assign w1c     = (bus.i_wr_en && (bus.i_addr == ADDR_ISR)) ? wsrc : '0;
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        spi_int_src u_src (
            .pclk    (pclk),
            .presetn (presetn),
            .flag    (i_flag[s]),
            .mode    (mode[s]),
            .w1c     (w1c[s]),
            .pend    (pend[s])
        );
    end
    always_comb begin
        rd_sel = (bus.i_addr == ADDR_IER) ? ier :
                 (bus.i_addr == ADDR_ISR) ? pend :
                 (bus.i_addr == ADDR_RAW) ? i_flag : mode;
    end
    // Reads capture pre-write register values, so a same-cycle write+read returns the old value.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ier         <= '0;
            mode        <= '0;
            o_int       <= 1'b0;
            bus.o_rdata <= '0;
        end else begin
            if (wr_ier) ier <= wsrc;
            if (wr_mode) mode <= wsrc;
            o_int <= |(pend & ier);
            if (bus.i_rd_en) bus.o_rdata <= DATA_W'(rd_sel);
        end
    end
endmodule
